// File: rtl/ram_burst_reader_pkg.sv
// Shared types for the RAM burst read initiator.
package ram_burst_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN
  } rd_state_e;

  localparam int unsigned FifoDepth = 2;

endpackage

// File: rtl/ram_burst_reader_fifo.sv
// Two-entry FIFO whose head entry is a register driving dout directly.
// Simultaneous write and read are accepted whenever the FIFO holds a word.
module ram_rd_fifo #(
  parameter int Dw = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [Dw-1:0] din,
  input  logic          rd_en,
  output logic [Dw-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic [1:0]    occ
);

  logic [Dw-1:0] head;
  logic [Dw-1:0] tail;
  logic [1:0]    cnt;
  logic          rd;
  logic          wr;

  assign rd    = rd_en && (cnt != 2'd0);
  assign wr    = wr_en && ((cnt != 2'd2) || rd);
  assign dout  = head;
  assign empty = (cnt == 2'd0);
  assign full  = (cnt == 2'd2);
  assign occ   = cnt;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the two data entries are ordinary flops, so they are cleared
      // along with the count; dout must read zero out of reset.
      head <= '0;
      tail <= '0;
      cnt  <= 2'd0;
    end else begin
      case (cnt)
        2'd0: begin
          if (wr) begin
            head <= din;
            cnt  <= 2'd1;
          end
        end
        2'd1: begin
          case ({wr, rd})
            2'b10: begin
              tail <= din;
              cnt  <= 2'd2;
            end
            2'b01: cnt <= 2'd0;
            2'b11: head <= din;
            default: ;
          endcase
        end
        2'd2: begin
          if (rd) begin
            head <= tail;
            if (wr) tail <= din;
            else    cnt  <= 2'd1;
          end
        end
        default: cnt <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read initiator: walks ram_addr over a wrapped address range and
// returns the read words on a valid/ready stream through a 2-entry FIFO.
module ram_burst_reader
  import ram_burst_reader_pkg::*;
#(
  parameter int Dw   = 32,
  parameter int Aw   = 10,
  parameter int LENw = Aw + 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [Aw-1:0]   start_addr,
  input  logic [LENw-1:0] burst_len,
  output logic            busy,
  output logic            done,
  output logic [Aw-1:0]   ram_addr,
  input  logic [Dw-1:0]   ram_q,
  output logic [Dw-1:0]   dout,
  output logic            dout_valid,
  input  logic            dout_ready
);

  rd_state_e       state;
  logic [LENw-1:0] issue_cnt;
  logic [LENw-1:0] pop_cnt;
  logic            inflight;
  logic            q_pend;
  logic            fifo_empty;
  logic            fifo_full;
  logic [1:0]      fifo_occ;
  logic            pop;
  logic            cap;
  logic [2:0]      occ_after;
  logic            can_issue;

  // inflight: ram_addr carries a fresh address this cycle.
  // q_pend: ram_q carries a word not yet captured. Because ram_addr is held
  // while nothing is issued, an uncaptured word simply re-appears on ram_q.
  assign dout_valid = !fifo_empty;
  assign pop        = dout_valid && dout_ready;
  assign cap        = q_pend && (!fifo_full || pop);
  assign occ_after  = {1'b0, fifo_occ} + 3'(cap) - 3'(pop);

  // Issuing now puts a new word on ram_q in two cycles; the word already on
  // its way must be guaranteed a FIFO slot next cycle even if ready drops.
  assign can_issue = (occ_after < 3'(FifoDepth));

  ram_rd_fifo #(.Dw(Dw)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (cap),
    .din     (ram_q),
    .rd_en   (pop),
    .dout    (dout),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .occ     (fifo_occ)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ram_addr  <= '0;
      issue_cnt <= '0;
      pop_cnt   <= '0;
      inflight  <= 1'b0;
      q_pend    <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= 1'b0;
      q_pend   <= inflight || (q_pend && !cap);
      if (pop) pop_cnt <= pop_cnt - LENw'(1);

      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (start) begin
            if (burst_len != '0) begin
              ram_addr  <= start_addr;
              inflight  <= 1'b1;
              issue_cnt <= burst_len - LENw'(1);
              pop_cnt   <= burst_len;
              busy      <= 1'b1;
              state     <= (burst_len == LENw'(1)) ? ST_DRAIN : ST_READ;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (can_issue) begin
            ram_addr  <= ram_addr + Aw'(1);
            inflight  <= 1'b1;
            issue_cnt <= issue_cnt - LENw'(1);
            if (issue_cnt == LENw'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // busy stays high through the done cycle and drops in IDLE.
          if (pop && pop_cnt == LENw'(1)) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Self-checking bench for ram_burst_reader: directed bursts plus randomized
// bursts and backpressure, checked against a queue of expected RAM words.
module tb_ram_burst_reader;

  localparam int Dw    = 32;
  localparam int Aw    = 4;
  localparam int LENw  = Aw + 1;
  localparam int Depth = 1 << Aw;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic [Aw-1:0]   start_addr = '0;
  logic [LENw-1:0] burst_len = '0;
  logic            busy;
  logic            done;
  logic [Aw-1:0]   ram_addr;
  logic [Dw-1:0]   ram_q = '0;
  logic [Dw-1:0]   dout;
  logic            dout_valid;
  logic            dout_ready = 1'b0;

  logic [Dw-1:0] mem [Depth];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Synchronous RAM without read enable: data follows the address by one clock.
  always @(posedge clk) ram_q <= mem[ram_addr];

  ram_burst_reader #(.Dw(Dw), .Aw(Aw), .LENw(LENw)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .burst_len  (burst_len),
    .busy       (busy),
    .done       (done),
    .ram_addr   (ram_addr),
    .ram_q      (ram_q),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ready_at(input int mode, input int cyc);
    case (mode)
      0: return 1'b1;
      1: begin
        case (cyc % 6)
          0, 3, 5: return 1'b1;
          default: return 1'b0;
        endcase
      end
      2: return 1'($urandom_range(0, 1));
      default: return ((cyc % 20) >= 8);
    endcase
  endfunction

  // One burst from start to done. mode selects the dout_ready pattern;
  // restart_cycle (>0) pulses a second, conflicting start mid-burst.
  task automatic run_burst(input logic [Aw-1:0] a, input logic [LENw-1:0] n,
                           input int mode, input int restart_cycle);
    logic [Dw-1:0] exp_q [$];
    logic [Aw-1:0] ad;
    logic [Aw-1:0] ahead;
    logic [Dw-1:0] prev_dout;
    logic          prev_stall;
    int            cyc;
    int            consumed;
    int            last_xfer;
    int            done_seen;

    exp_q.delete();
    for (int k = 0; k < int'(n); k++) begin
      ad = a + Aw'(k);
      exp_q.push_back(mem[ad]);
    end

    dout_ready = ready_at(mode, 0);
    start      = 1'b1;
    start_addr = a;
    burst_len  = n;
    step();
    start      = 1'b0;
    start_addr = Aw'($urandom);
    burst_len  = LENw'($urandom);
    check("first_addr", 32'(ram_addr), 32'(a));

    cyc        = 1;
    consumed   = 0;
    last_xfer  = -1;
    done_seen  = 0;
    prev_stall = 1'b0;
    prev_dout  = '0;
    while (done_seen == 0 && cyc < 400) begin
      dout_ready = ready_at(mode, cyc);
      if (cyc == restart_cycle) begin
        start      = 1'b1;
        start_addr = a + Aw'(7);
        burst_len  = LENw'(3);
      end
      check("busy", 32'(busy), 32'(1));
      check("done", 32'(done), 32'(last_xfer >= 0 && consumed == int'(n) && cyc == last_xfer + 1));
      if (done) done_seen = 1;
      if (prev_stall) begin
        check("hold_valid", 32'(dout_valid), 32'(1));
        check("hold_data", dout, prev_dout);
      end
      if (consumed < int'(n)) begin
        ahead = ram_addr - (a + Aw'(consumed));
        check("addr_ahead_le2", 32'(ahead <= Aw'(2)), 32'(1));
      end else begin
        check("valid_after_last", 32'(dout_valid), 32'(0));
      end
      if (mode == 0)
        check("valid_timing", 32'(dout_valid), 32'(cyc >= 3 && cyc < 3 + int'(n)));
      if (dout_valid && dout_ready && consumed < int'(n)) begin
        check("data", dout, exp_q[consumed]);
        consumed++;
        last_xfer = cyc;
      end
      prev_stall = dout_valid && !dout_ready;
      prev_dout  = dout;
      step();
      start = 1'b0;
      cyc++;
    end
    check("done_seen", 32'(done_seen), 32'(1));
    check("word_count", 32'(consumed), 32'(n));
    check("busy_after", 32'(busy), 32'(0));
    check("done_single", 32'(done), 32'(0));
  endtask

  initial begin
    for (int i = 0; i < Depth; i++) mem[i] = Dw'(i);
    dout_ready = 1'b1;

    #12;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_addr", 32'(ram_addr), 32'(0));
    check("rst_valid", 32'(dout_valid), 32'(0));
    check("rst_dout", dout, 32'(0));
    step();
    reset_n = 1'b1;
    step();

    run_burst(Aw'(5), LENw'(4), 0, -1);
    run_burst(Aw'(5), LENw'(4), 1, -1);
    run_burst(Aw'(14), LENw'(4), 0, -1);
    run_burst(Aw'(5), LENw'(4), 0, 2);
    run_burst(Aw'(9), LENw'(16), 1, -1);
    run_burst(Aw'(0), LENw'(16), 3, -1);
    run_burst(Aw'(3), LENw'(1), 2, -1);

    // Zero-length command: one done pulse, never busy, never valid.
    start      = 1'b1;
    start_addr = Aw'(3);
    burst_len  = '0;
    step();
    start = 1'b0;
    check("zl_done", 32'(done), 32'(1));
    check("zl_busy", 32'(busy), 32'(0));
    check("zl_valid", 32'(dout_valid), 32'(0));
    for (int i = 0; i < 3; i++) begin
      step();
      check("zl_done_clear", 32'(done), 32'(0));
      check("zl_busy_clear", 32'(busy), 32'(0));
      check("zl_no_valid", 32'(dout_valid), 32'(0));
    end

    // Reset after two of eight words have been consumed.
    dout_ready = 1'b1;
    start      = 1'b1;
    start_addr = '0;
    burst_len  = LENw'(8);
    step();
    start = 1'b0;
    step();
    step();
    check("rb_word0", dout, mem[0]);
    step();
    check("rb_word1", dout, mem[1]);
    step();
    reset_n = 1'b0;
    #1;
    check("rb_busy", 32'(busy), 32'(0));
    check("rb_done", 32'(done), 32'(0));
    check("rb_addr", 32'(ram_addr), 32'(0));
    check("rb_valid", 32'(dout_valid), 32'(0));
    check("rb_dout", dout, 32'(0));
    step();
    step();
    reset_n = 1'b1;
    step();
    check("rb_no_done", 32'(done), 32'(0));
    run_burst(Aw'(0), LENw'(2), 0, -1);

    // Random contents, addresses, lengths and backpressure.
    for (int i = 0; i < Depth; i++) mem[i] = $urandom;
    for (int b = 0; b < 12; b++)
      run_burst(Aw'($urandom), LENw'($urandom_range(1, Depth)), 1 + (b % 3), -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
